// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared definitions for the seven-segment scan driver:
//   - scan_state_e : slot phase, GAP (all digits dark) or SHOW (one digit lit)
//   - SEG7_TABLE   : active-high segment patterns for hex digits 0..F,
//                    bit 6 = segment A ... bit 0 = segment G
package seg7_pkg;

    typedef enum logic {
        GAP  = 1'b0,
        SHOW = 1'b1
    } scan_state_e;

    localparam logic [6:0] SEG7_TABLE [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79,   // 0 1 2 3
        7'h33, 7'h5B, 7'h5F, 7'h70,   // 4 5 6 7
        7'h7F, 7'h7B, 7'h77, 7'h1F,   // 8 9 A b
        7'h4E, 7'h3D, 7'h4F, 7'h47    // C d E F
    };

endpackage

// File: rtl/seg7_encode.sv
// seg7_encode
// Purely combinational hex-to-seven-segment decoder (active-high).
// Ports:
//   i_Nibble   in  4  hex digit to display
//   o_Segments out 7  segments A..G, bit 6 = A, bit 0 = G
module seg7_encode
    import seg7_pkg::*;
(
    input  logic [3:0] i_Nibble,
    output logic [6:0] o_Segments
);

    assign o_Segments = SEG7_TABLE[i_Nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexed driver for a DIGITS-wide hex seven-segment display.
// Each digit owns a slot of REFRESH_DIV cycles; the first GAP_CYCLES of a
// slot keep every digit dark to suppress ghosting. A new value is taken
// through a valid/ready handshake into a shadow register and only copied to
// the displayed register at a frame boundary, so a frame never mixes values.
// Ports:
//   i_Clk       in  1          clock, rising edge
//   i_Rst       in  1          synchronous active-high reset
//   i_Valid     in  1          new display value offered
//   i_Value     in  4*DIGITS   nibble k drives digit k (k=0 rightmost)
//   i_Blank_LZ  in  1          blank leading zeros
//   o_Ready     out 1          driver can accept a value
//   o_Segments  out 7          segments A..G (bit 6 = A), registered
//   o_Digit_En  out DIGITS     digit enables, at most one active, registered
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 25000,
    parameter int GAP_CYCLES  = 250,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic                  i_Valid,
    input  logic [4*DIGITS-1:0]   i_Value,
    input  logic                  i_Blank_LZ,
    output logic                  o_Ready,
    output logic [6:0]            o_Segments,
    output logic [DIGITS-1:0]     o_Digit_En
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [DIG_W-1:0] DIG_MAX  = DIG_W'(DIGITS - 1);

    localparam scan_state_e RESET_STATE = (GAP_CYCLES > 0) ? GAP : SHOW;

    // "Off" levels of the pins; XOR with these converts active-high to pin polarity.
    localparam logic [6:0]        SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [DIGITS-1:0] EN_OFF  = (ACTIVE_LOW != 0) ? '1 : '0;

    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    logic [DIG_W-1:0]    dig_q,    dig_d;
    scan_state_e         state_q,  state_d;
    logic [4*DIGITS-1:0] disp_q,   disp_d;
    logic [4*DIGITS-1:0] shadow_q, shadow_d;
    logic                pend_q,   pend_d;
    logic [6:0]          seg_q,    seg_d;
    logic [DIGITS-1:0]   en_q,     en_d;

    logic                slot_end;
    logic                frame_end;
    logic                accept;
    logic                seen;
    logic [DIGITS-1:0]   keep;
    logic [DIGITS-1:0]   onehot;
    logic [3:0]          nibble;
    logic [6:0]          glyph;

    // ---------------- slot counter and digit index ----------------
    // NOTE: every signal assigned in an always_comb gets a default at the top,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        slot_end  = (cnt_q == CNT_MAX);
        frame_end = slot_end && (dig_q == DIG_MAX);
        cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
        dig_d     = dig_q;
        if (slot_end) begin
            dig_d = (dig_q == DIG_MAX) ? '0 : dig_q + 1'b1;
        end
    end

    // ---------------- slot FSM ----------------
    // GAP covers counter values 0..GAP_CYCLES-1, SHOW the rest of the slot.
    always_comb begin
        state_d = state_q;
        case (state_q)
            GAP:     if (cnt_q == GAP_LAST) state_d = SHOW;
            SHOW:    if (slot_end && (GAP_CYCLES > 0)) state_d = GAP;
            default: state_d = RESET_STATE;
        endcase
    end

    // ---------------- value handshake ----------------
    // accept and the frame-boundary load are mutually exclusive (one needs
    // pend_q low, the other high), so an accept on the boundary cycle waits
    // for the next boundary.
    always_comb begin
        accept   = i_Valid && !pend_q;
        shadow_d = accept ? i_Value : shadow_q;
        pend_d   = pend_q;
        disp_d   = disp_q;
        if (accept) begin
            pend_d = 1'b1;
        end else if (frame_end && pend_q) begin
            disp_d = shadow_q;
            pend_d = 1'b0;
        end
    end

    assign o_Ready = !pend_q;

    // ---------------- leading-zero blanking ----------------
    // Scan from the most significant digit down; a digit stays lit once any
    // nibble at or above it is non-zero. Digit 0 is always kept.
    always_comb begin
        seen = 1'b0;
        keep = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            seen    = seen | (disp_q[4*k +: 4] != 4'h0);
            keep[k] = seen || (k == 0) || !i_Blank_LZ;
        end
    end

    // ---------------- digit mux, encode, output staging ----------------
    assign nibble = disp_q[{dig_q, 2'b00} +: 4];

    seg7_encode u_encode (
        .i_Nibble   (nibble),
        .o_Segments (glyph)
    );

    always_comb begin
        onehot = DIGITS'(1) << dig_q;
        seg_d  = SEG_OFF;
        en_d   = EN_OFF;
        if ((state_q == SHOW) && keep[dig_q]) begin
            seg_d = glyph  ^ SEG_OFF;
            en_d  = onehot ^ EN_OFF;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            cnt_q    <= '0;
            dig_q    <= '0;
            state_q  <= RESET_STATE;
            disp_q   <= '0;
            shadow_q <= '0;
            pend_q   <= 1'b0;
            seg_q    <= SEG_OFF;
            en_q     <= EN_OFF;
        end else begin
            cnt_q    <= cnt_d;
            dig_q    <= dig_d;
            state_q  <= state_d;
            disp_q   <= disp_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            seg_q    <= seg_d;
            en_q     <= en_d;
        end
    end

    assign o_Segments = seg_q;
    assign o_Digit_En = en_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver
// Directed bench for seg7_scan_driver with DIGITS=4, REFRESH_DIV=8,
// GAP_CYCLES=2, ACTIVE_LOW=0. A frame is 32 cycles; k counts rising edges
// since the last reset edge, and the outputs seen after edge k belong to
// output frame (k-1)/32. Each frame is summarised per digit (enabled
// cycles, segment pattern) and compared with hand-derived values.
module tb_seg7_scan_driver;

    localparam int DIGITS = 4;

    logic              clk;
    logic              rst;
    logic              valid;
    logic [15:0]       value;
    logic              blank;
    logic              ready;
    logic [6:0]        seg;
    logic [DIGITS-1:0] en;

    int checks;
    int errors;
    int k;
    int en_cnt [DIGITS];
    logic [6:0] seg_seen [DIGITS];
    bit varied [DIGITS];
    int frame_bad;

    seg7_scan_driver #(
        .DIGITS      (4),
        .REFRESH_DIV (8),
        .GAP_CYCLES  (2),
        .ACTIVE_LOW  (0)
    ) dut (
        .i_Clk      (clk),
        .i_Rst      (rst),
        .i_Valid    (valid),
        .i_Value    (value),
        .i_Blank_LZ (blank),
        .o_Ready    (ready),
        .o_Segments (seg),
        .o_Digit_En (en)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock; sample 1 ns after the edge and fold into the frame summary.
    task automatic step();
        @(posedge clk);
        #1;
        k++;
        if ((k - 1) % 32 == 0) begin
            frame_bad = 0;
            for (int d = 0; d < DIGITS; d++) begin
                en_cnt[d]   = 0;
                seg_seen[d] = 7'h00;
                varied[d]   = 1'b0;
            end
        end
        if (!$onehot0(en) || (en == '0 && seg != 7'h00)) frame_bad++;
        for (int d = 0; d < DIGITS; d++) begin
            if (en[d]) begin
                if (en_cnt[d] == 0) seg_seen[d] = seg;
                else if (seg != seg_seen[d]) varied[d] = 1'b1;
                en_cnt[d]++;
            end
        end
    endtask

    task automatic run_to(input int target);
        while (k < target) step();
    endtask

    // exp[d] = expected pattern of digit d; 0 means the digit must stay dark.
    task automatic check_frame(input string tag, input logic [3:0][6:0] exp);
        for (int d = 0; d < DIGITS; d++) begin
            int exp_cnt;
            exp_cnt = (exp[d] != 7'h00) ? 6 : 0;
            check($sformatf("%s d%0d en_cycles", tag, d), en_cnt[d], exp_cnt);
            if (exp_cnt != 0) begin
                check($sformatf("%s d%0d seg", tag, d), {25'd0, seg_seen[d]}, {25'd0, exp[d]});
                check($sformatf("%s d%0d stable", tag, d), {31'd0, varied[d]}, 32'd0);
            end
        end
        check($sformatf("%s dark_or_onehot", tag), frame_bad, 0);
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; valid = 1'b0; value = 16'h0; blank = 1'b0;
        checks = 0; errors = 0; k = 0; frame_bad = 0;

        // Reset state
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst ready", {31'd0, ready}, 32'd1);
        check("rst seg", {25'd0, seg}, 32'd0);
        check("rst en", {28'd0, en}, 32'd0);
        rst = 1'b0;
        k = 0;

        // Two gap cycles, then digit 0 lit with 0
        step(); check("k1 en", {28'd0, en}, 32'd0);
        step(); check("k2 en", {28'd0, en}, 32'd0);
        step(); check("k3 en", {28'd0, en}, 32'd1);
        check("k3 seg", {25'd0, seg}, 32'h7E);
        run_to(32);
        check_frame("f0", {7'h7E, 7'h7E, 7'h7E, 7'h7E});

        // Mid-frame accept of 0x12AF, then valid held with changing data
        run_to(40);
        valid = 1'b1; value = 16'h12AF;
        step();
        check("acc ready_low", {31'd0, ready}, 32'd0);
        while (k < 63) begin
            value = 16'(16'h3000 + k);
            step();
        end
        valid = 1'b0;
        check("pre_bnd ready", {31'd0, ready}, 32'd0);
        step();
        check("post_bnd ready", {31'd0, ready}, 32'd1);
        check_frame("f1_old", {7'h7E, 7'h7E, 7'h7E, 7'h7E});
        run_to(96);
        check_frame("f2_12AF", {7'h30, 7'h6D, 7'h77, 7'h47});

        // Leading-zero blanking with 0x0005
        valid = 1'b1; value = 16'h0005;
        step();
        valid = 1'b0;
        check("acc5 ready_low", {31'd0, ready}, 32'd0);
        run_to(128);
        check_frame("f3_12AF", {7'h30, 7'h6D, 7'h77, 7'h47});
        blank = 1'b1;

        // Accept 0x0000 on the boundary cycle itself
        run_to(159);
        valid = 1'b1; value = 16'h0000;
        step();
        valid = 1'b0;
        check("bnd_acc ready_low", {31'd0, ready}, 32'd0);
        check_frame("f4_0005", {7'h00, 7'h00, 7'h00, 7'h5B});
        run_to(191);
        check("bnd_wait ready", {31'd0, ready}, 32'd0);
        step();
        check("bnd_done ready", {31'd0, ready}, 32'd1);
        check_frame("f5_held", {7'h00, 7'h00, 7'h00, 7'h5B});
        run_to(224);
        check_frame("f6_zero_blank", {7'h00, 7'h00, 7'h00, 7'h7E});

        // Reset while a value is pending; reset wins over valid
        blank = 1'b0;
        run_to(232);
        valid = 1'b1; value = 16'h8888;
        step();
        valid = 1'b0;
        check("pend ready_low", {31'd0, ready}, 32'd0);
        run_to(240);
        rst = 1'b1; valid = 1'b1; value = 16'h9999;
        @(posedge clk); #1;
        check("mid_rst seg", {25'd0, seg}, 32'd0);
        check("mid_rst en", {28'd0, en}, 32'd0);
        check("mid_rst ready", {31'd0, ready}, 32'd1);
        rst = 1'b0; valid = 1'b0;
        k = 0;
        run_to(32);
        check_frame("r0", {7'h7E, 7'h7E, 7'h7E, 7'h7E});
        run_to(64);
        check_frame("r1_discard", {7'h7E, 7'h7E, 7'h7E, 7'h7E});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
